sdcard_perf_window_ctrl: RTL and testbench
==========================================

SDCARD_PERF_WINDOW_CTRL -- requirements
Module: sdcard_perf_window_ctrl

Interface
REQ-001 SHALL have parameter NUM_CTR, default 4, meaning number of activity counters; the drain order is fixed at cmd, data, dma, idle.
REQ-002 SHALL have ports:
  PCLK_i  in  1  single clock; all logic on its rising edge.
  PRESETn_i  in  1  reset; asynchronous, active-low.
  cfg_enable  in  1  block enable; low forces the window FSM to IDLE.
  cfg_window_len  in  16  window length in cycles; 0 is treated as 1.
  cfg_oneshot  in  1  1: single window, then IDLE; 0: windows run back-to-back.
  sw_start  in  1  start pulse.
  sw_stop  in  1  stop pulse.
  cmd_busy / data_busy / dma_busy  in  1 each  activity inputs.
  snap_valid  out  1  snapshot word valid.
  snap_ready  in  1  consumer accepts the word.
  snap_data  out  16  counter value.
  snap_idx  out  2  counter index, 0..3.
  snap_sat  out  1  this counter saturated in its window.
  snap_last  out  1  marks idx 3.
  running  out  1  window FSM is in RUN.
  window_done  out  1  one-cycle pulse on capture.
  overrun_cnt  out  8  count of dropped snapshots, saturating.

Function
REQ-003 The window FSM SHALL have two states, IDLE and RUN.
REQ-004 IDLE->RUN SHALL occur on sw_start && cfg_enable && !sw_stop; that same cycle SHALL clear the live counters, the window counter and the saturation flags.
REQ-005 RUN->IDLE SHALL occur on sw_stop or !cfg_enable; no capture occurs; live counters hold their values.
REQ-006 While in RUN, each cycle SHALL increment the live counters as follows:
  - cmd when cmd_busy;
  - data when data_busy;
  - dma when dma_busy;
  - idle when none of the three is busy.
  The window counter SHALL increment every RUN cycle.
REQ-007 Live counters SHALL saturate at 16'hFFFF; an attempted increment at FFFF SHALL set that counter's sat flag.
REQ-008 Capture cycle: the RUN cycle in which window counter == effective_len-1.
REQ-009 On the capture cycle, the shadow registers SHALL receive live value plus that cycle's increment, saturated, along with the sat flags; window_done SHALL pulse.
REQ-010 After the capture cycle, live counters, window counter and sat flags SHALL be 0 on the next cycle.
REQ-011 After capture, the FSM SHALL stay in RUN if cfg_oneshot=0, else go to IDLE.
REQ-012 A sw_stop or !cfg_enable on the capture cycle SHALL win: no capture, no window_done.
REQ-013 The drain FSM SHALL have states D_IDLE and D_BUSY and SHALL run independently of the window FSM.
REQ-014 A capture in D_IDLE SHALL enter D_BUSY next cycle with idx=0 and snap_valid=1.
REQ-015 In D_BUSY, snap_data, snap_idx, snap_sat and snap_last SHALL be stable while snap_valid && !snap_ready.
REQ-016 A handshake (snap_valid && snap_ready) SHALL advance idx by 1; a handshake at idx 3 SHALL return to D_IDLE with snap_valid=0 next cycle; throughput is 1 word/cycle.
REQ-017 A capture while D_BUSY SHALL leave the shadow registers unchanged, drop the new snapshot, and increment overrun_cnt, saturating at 8'hFF.
REQ-018 A capture on the same cycle as the final handshake (idx 3) SHALL be accepted, not dropped: the drain re-enters D_BUSY at idx 0 with no idle cycle.
REQ-019 snap_last SHALL be 1 iff snap_valid && idx==3.
REQ-020 snap_data and snap_sat SHALL be 0 when snap_valid=0.
REQ-021 The running output SHALL be 1 iff the window FSM is in RUN.
REQ-022 Changes to cfg_window_len during RUN SHALL take effect on the next comparison.
REQ-023 If the new cfg_window_len is at or below the current window count, the window SHALL continue to wrap at 16'hFFFF and capture on the next match.

Reset
REQ-024 On PRESETn_i low, the block SHALL asynchronously enter IDLE and D_IDLE; all counters, shadows, sat flags and overrun_cnt SHALL be 0.
REQ-025 On PRESETn_i low, the outputs snap_valid, snap_data, snap_idx, snap_sat, snap_last, running and window_done SHALL be 0.
REQ-026 Reset asserted mid-drain or mid-window SHALL abort with no further output; after release the block SHALL wait for sw_start.

Verification
REQ-027 len=8, oneshot=1, cmd_busy always 1, others 0, ready=1 -> window_done at RUN cycle 8; words {8,0,0,0}, idx 0..3, last on idx 3; running=0 afterwards.
REQ-028 len=4, continuous, ready held 0 for 10 cycles -> first snapshot held stable; two later captures dropped; overrun_cnt=2.
REQ-029 len=0 (so window of 1 cycle), all busy 0 -> capture every cycle, each snapshot {0,0,0,1}.
REQ-030 len=16'hFFFF, cmd_busy=1, a second window run past saturation (total cmd count >65535) -> cmd word = FFFF with snap_sat=1 on idx 0; other words snap_sat=0.
REQ-031 sw_start and sw_stop in the same cycle -> stays IDLE; sw_stop on the capture cycle -> no window_done and no snapshot.
REQ-032 Reset pulsed at idx 2 of a drain -> snap_valid=0 immediately and overrun_cnt=0; after the next sw_start the drain begins at idx 0.

Source files
------------

// File: rtl/sdcard_perf_window_ctrl.sv
// Windowed activity counters for an SD card host: counts cmd/data/dma/idle cycles per window
// and drains each captured snapshot as four words over a valid/ready port.
module sdcard_perf_window_ctrl #(
  parameter int NUM_CTR = 4
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        cfg_enable,
  input  logic [15:0] cfg_window_len,
  input  logic        cfg_oneshot,
  input  logic        sw_start,
  input  logic        sw_stop,
  input  logic        cmd_busy,
  input  logic        data_busy,
  input  logic        dma_busy,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [15:0] snap_data,
  output logic [1:0]  snap_idx,
  output logic        snap_sat,
  output logic        snap_last,
  output logic        running,
  output logic        window_done,
  output logic [7:0]  overrun_cnt
);

  localparam logic W_IDLE = 1'b0;
  localparam logic W_RUN  = 1'b1;
  localparam logic D_IDLE = 1'b0;
  localparam logic D_BUSY = 1'b1;

  logic               win_state;
  logic               drn_state;
  logic [15:0]        win_cnt;
  logic [15:0]        win_last;
  logic [1:0]         idx;
  logic [7:0]         ovr;
  logic [3:0]         act;
  logic               start_ok;
  logic               abort;
  logic               run_step;
  logic               capture;
  logic               handshake;
  logic               accept;
  logic [15:0]        shd_val [NUM_CTR];
  logic [NUM_CTR-1:0] shd_flag;

  function automatic logic [16:0] sat_inc16(input logic [15:0] v, input logic inc);
    if (inc && (v == 16'hFFFF)) return {1'b1, v};
    return {1'b0, v + {15'd0, inc}};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign act       = {~(cmd_busy | data_busy | dma_busy), dma_busy, data_busy, cmd_busy};
  assign win_last  = (cfg_window_len == 16'd0) ? 16'd0 : cfg_window_len - 16'd1;
  assign start_ok  = (win_state == W_IDLE) && sw_start && cfg_enable && !sw_stop;
  assign abort     = (win_state == W_RUN) && (sw_stop || !cfg_enable);
  assign run_step  = (win_state == W_RUN) && !abort;
  assign capture   = run_step && (win_cnt == win_last);
  assign handshake = snap_valid && snap_ready;
  // The idx-3 word leaves this cycle, so the shadows may reload without a bubble.
  assign accept    = capture && ((drn_state == D_IDLE) || (handshake && (idx == 2'd3)));

  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
    logic [15:0] cnt;
    logic [15:0] shd;
    logic        sat;
    logic        shd_sat;
    logic [16:0] nxt;

    assign nxt = sat_inc16(cnt, act[g]);

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
      if (!PRESETn_i) begin
        cnt     <= '0;
        sat     <= 1'b0;
        shd     <= '0;
        shd_sat <= 1'b0;
      end else begin
        if (start_ok || capture) begin
          cnt <= '0;
          sat <= 1'b0;
        end else if (run_step) begin
          cnt <= nxt[15:0];
          sat <= sat | nxt[16];
        end
        if (accept) begin
          shd     <= nxt[15:0];
          shd_sat <= sat | nxt[16];
        end
      end
    end

    assign shd_val[g]  = shd;
    assign shd_flag[g] = shd_sat;
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      win_state <= W_IDLE;
      win_cnt   <= '0;
    end else if (start_ok) begin
      win_state <= W_RUN;
      win_cnt   <= '0;
    end else if (abort) begin
      win_state <= W_IDLE;
    end else if (capture) begin
      win_cnt <= '0;
      if (cfg_oneshot) win_state <= W_IDLE;
    end else if (run_step) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      drn_state <= D_IDLE;
      idx       <= '0;
      ovr       <= '0;
    end else if (accept) begin
      drn_state <= D_BUSY;
      idx       <= '0;
    end else begin
      if (capture) ovr <= sat_inc8(ovr);
      if (handshake) begin
        if (idx == 2'd3) begin
          drn_state <= D_IDLE;
          idx       <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  assign snap_valid  = (drn_state == D_BUSY);
  assign snap_idx    = idx;
  assign snap_data   = snap_valid ? shd_val[idx] : 16'd0;
  assign snap_sat    = snap_valid & shd_flag[idx];
  assign snap_last   = snap_valid && (idx == 2'd3);
  assign running     = (win_state == W_RUN);
  assign window_done = capture;
  assign overrun_cnt = ovr;

endmodule

// File: tb/tb_sdcard_perf_window_ctrl.sv
// Bench for sdcard_perf_window_ctrl: directed vector table, corner sequences and random
// traffic compared every cycle against a queue-based reference model.
module tb_sdcard_perf_window_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, oneshot, start, stop, cmd, dat, dma, ready;
  logic [15:0] len;
  logic        snap_valid, snap_sat, snap_last, running, window_done;
  logic [15:0] snap_data;
  logic [1:0]  snap_idx;
  logic [7:0]  overrun_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdcard_perf_window_ctrl #(.NUM_CTR(4)) dut (
    .PCLK_i        (clk),
    .PRESETn_i     (rst_n),
    .cfg_enable    (en),
    .cfg_window_len(len),
    .cfg_oneshot   (oneshot),
    .sw_start      (start),
    .sw_stop       (stop),
    .cmd_busy      (cmd),
    .data_busy     (dat),
    .dma_busy      (dma),
    .snap_valid    (snap_valid),
    .snap_ready    (ready),
    .snap_data     (snap_data),
    .snap_idx      (snap_idx),
    .snap_sat      (snap_sat),
    .snap_last     (snap_last),
    .running       (running),
    .window_done   (window_done),
    .overrun_cnt   (overrun_cnt)
  );

  // Reference model: plain integer counters plus a queue of pending snapshot words.
  typedef struct { int data; int idx; bit sat; } word_t;
  word_t m_q[$];
  bit    m_run;
  int    m_cnt [4];
  bit    m_sat [4];
  int    m_win;
  int    m_ovr;

  typedef struct {
    logic start, ready;
    logic e_run, e_done, e_valid;
    logic [15:0] e_data;
    logic [1:0]  e_idx;
    logic        e_last;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_capture();
    int eff_last;
    eff_last = (len == 16'd0) ? 0 : int'(len) - 1;
    return m_run && !stop && en && (m_win == eff_last);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_win = 0;
    m_ovr = 0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_sat[i] = 1'b0;
    end
    m_q.delete();
  endtask

  task automatic model_check();
    chk("running", running, m_run);
    chk("window_done", window_done, m_capture());
    if (m_q.size() > 0) begin
      chk("snap_valid", snap_valid, 1);
      chk("snap_data", snap_data, m_q[0].data);
      chk("snap_idx", snap_idx, m_q[0].idx);
      chk("snap_sat", snap_sat, m_q[0].sat);
      chk("snap_last", snap_last, m_q[0].idx == 3);
    end else begin
      chk("snap_valid", snap_valid, 0);
      chk("snap_data_idle", snap_data, 0);
      chk("snap_idx_idle", snap_idx, 0);
      chk("snap_sat_idle", snap_sat, 0);
      chk("snap_last_idle", snap_last, 0);
    end
    chk("overrun_cnt", overrun_cnt, m_ovr);
  endtask

  task automatic model_step();
    bit cap, hs;
    bit act [4];
    int sd [4];
    bit ss [4];
    cap = m_capture();
    hs  = (m_q.size() > 0) && ready;
    act[0] = cmd; act[1] = dat; act[2] = dma; act[3] = !(cmd || dat || dma);
    if (!m_run) begin
      if (start && en && !stop) begin
        m_run = 1'b1;
        m_win = 0;
        for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_sat[i] = 1'b0; end
      end
    end else if (stop || !en) begin
      m_run = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (act[i]) begin
          if (m_cnt[i] == 65535) m_sat[i] = 1'b1;
          else m_cnt[i]++;
        end
      m_win = (m_win + 1) % 65536;
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          sd[i] = m_cnt[i]; ss[i] = m_sat[i];
          m_cnt[i] = 0; m_sat[i] = 1'b0;
        end
        m_win = 0;
        if (oneshot) m_run = 1'b0;
      end
    end
    if (hs) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() == 0) begin
        for (int i = 0; i < 4; i++) m_q.push_back('{sd[i], i, ss[i]});
      end else if (m_ovr < 255) begin
        m_ovr++;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic settle();
    int n;
    n = 0;
    en = 1'b1; start = 1'b0; ready = 1'b1;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    while ((m_q.size() > 0 || m_run) && n < 40) begin
      cycle();
      n++;
    end
    chk("settle_in_budget", n < 40, 1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_snap_data", snap_data, 0);
    chk("rst_snap_idx", snap_idx, 0);
    chk("rst_snap_sat", snap_sat, 0);
    chk("rst_snap_last", snap_last, 0);
    chk("rst_running", running, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_overrun", overrun_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_head_idx2();
    int n;
    n = 0;
    while (!(m_q.size() > 0 && m_q[0].idx == 2) && n < 30) begin
      cycle();
      n++;
    end
    chk("r32_reached_idx2", n < 30, 1);
  endtask

  task automatic wait_capture(input int budget);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      sample();
      seen = window_done;
      advance();
      n++;
    end
    chk("r30_capture_seen", seen, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1; oneshot = 1'b1; start = 1'b0; stop = 1'b0;
    cmd = 1'b1; dat = 1'b0; dma = 1'b0; ready = 1'b1; len = 16'd8;

    // len 8, oneshot, cmd busy: capture on RUN cycle 8, words {8,0,0,0}
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd8, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 1'b0};

    #1;
    model_reset();
    chk("init_snap_valid", snap_valid, 0);
    chk("init_running", running, 0);
    chk("init_window_done", window_done, 0);
    chk("init_overrun", overrun_cnt, 0);
    chk("init_snap_last", snap_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      start = tbl[r].start;
      ready = tbl[r].ready;
      sample();
      chk("t27_running", running, tbl[r].e_run);
      chk("t27_window_done", window_done, tbl[r].e_done);
      chk("t27_snap_valid", snap_valid, tbl[r].e_valid);
      chk("t27_snap_data", snap_data, tbl[r].e_data);
      chk("t27_snap_idx", snap_idx, tbl[r].e_idx);
      chk("t27_snap_last", snap_last, tbl[r].e_last);
      advance();
    end
    start = 1'b0;

    // len 4 continuous, consumer stalled: first snapshot held, two captures dropped
    len = 16'd4; oneshot = 1'b0; ready = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    run_n(4);
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("r28_valid_held", snap_valid, 1);
      chk("r28_idx_held", snap_idx, 0);
      chk("r28_data_held", snap_data, 4);
      if (k == 9) chk("r28_overrun", overrun_cnt, 2);
      advance();
    end
    settle();

    // reset in the middle of a drain
    len = 16'd4; oneshot = 1'b1; cmd = 1'b1; ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    wait_head_idx2();
    chk("r32_overrun_before", overrun_cnt, 2);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("r32_waits_idle", running, 0);
      advance();
    end
    start = 1'b1; cycle(); start = 1'b0;
    run_n(4);
    sample();
    chk("r32_restart_valid", snap_valid, 1);
    chk("r32_restart_idx", snap_idx, 0);
    chk("r32_restart_data", snap_data, 4);
    advance();
    settle();

    // start with stop in the same cycle; stop on the capture cycle
    len = 16'd4; oneshot = 1'b1;
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    sample();
    chk("r31_no_start", running, 0);
    advance();
    start = 1'b1; cycle(); start = 1'b0;
    run_n(3);
    stop = 1'b1;
    sample();
    chk("r31_no_done", window_done, 0);
    advance();
    stop = 1'b0;
    sample();
    chk("r31_idle_after_stop", running, 0);
    chk("r31_no_snapshot", snap_valid, 0);
    advance();
    run_n(4);

    // len 0: capture every cycle, back-to-back drains of {0,0,0,1}
    len = 16'd0; oneshot = 1'b0; cmd = 1'b0; dat = 1'b0; dma = 1'b0; ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    sample();
    chk("r29_first_done", window_done, 1);
    advance();
    for (int k = 0; k < 12; k++) begin
      sample();
      chk("r29_done", window_done, 1);
      chk("r29_valid", snap_valid, 1);
      chk("r29_idx", snap_idx, k % 4);
      chk("r29_data", snap_data, (k % 4 == 3) ? 1 : 0);
      advance();
    end
    ready = 1'b0;
    run_n(300);
    sample();
    chk("r29_overrun_saturates", overrun_cnt, 255);
    advance();
    settle();

    // len FFFF shortened mid-window: counter wraps, cmd count passes 65535 and saturates
    en = 1'b1; oneshot = 1'b1; len = 16'hFFFF; cmd = 1'b1; dat = 1'b0; dma = 1'b0; ready = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    run_n(10);
    len = 16'd3;
    wait_capture(70000);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("r30_valid", snap_valid, 1);
      chk("r30_idx", snap_idx, k);
      chk("r30_data", snap_data, (k == 0) ? 65535 : 0);
      chk("r30_sat", snap_sat, k == 0);
      advance();
    end
    settle();

    do_reset();
    len = 16'd3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 59) != 0);
      oneshot = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) len = 16'($urandom_range(0, 9));
      cmd     = 1'($urandom_range(0, 1));
      dat     = 1'($urandom_range(0, 1));
      dma     = 1'($urandom_range(0, 1));
      ready   = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
